csr_trap_sequencer: RTL and testbench

//  Controller in front of the machine-mode CSR file. Owns the CSR file's single access port and

---
 rtl/csr_trap_sequencer.sv | 163 ++++++++++++++++
 tb/tb_csr_trap_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_sequencer.sv
// csr_trap_sequencer: owns the machine-mode CSR file port, arbitrating it between
// core CSR instructions and the sequencer's own trap entry / mret return sequences.
// Optional feature macro: VECTORED_TRAP_EN (vectored interrupt targets from mtvec mode 01).
module csr_trap_sequencer #(
    parameter int unsigned MXLEN       = 32,
    parameter logic [11:0] MTVEC_ADDR  = 12'h305,
    parameter logic [11:0] MEPC_ADDR   = 12'h341,
    parameter logic [11:0] MCAUSE_ADDR = 12'h342
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trap_req,
    input  logic [MXLEN-1:0] trap_pc,
    input  logic [MXLEN-1:0] trap_cause,
    output logic             trap_ack,
    input  logic             mret_req,
    output logic             mret_ack,
    input  logic             core_csr_req,
    input  logic             core_csr_op,
    input  logic [11:0]      core_csr_addr,
    input  logic [MXLEN-1:0] core_csr_wdata,
    output logic             core_csr_gnt,
    output logic [MXLEN-1:0] core_csr_rdata,
    output logic             core_csr_err,
    output logic             csr_en,
    output logic             csr_op,
    output logic [11:0]      csr_addr,
    output logic [MXLEN-1:0] csr_wdata,
    input  logic [MXLEN-1:0] csr_rdata,
    input  logic             csr_err,
    output logic             redirect_valid,
    output logic [MXLEN-1:0] redirect_pc,
    output logic             seq_err,
    output logic             busy
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WR_EPC   = 3'd1;
    localparam logic [2:0] S_WR_CAUSE = 3'd2;
    localparam logic [2:0] S_RD_TVEC  = 3'd3;
    localparam logic [2:0] S_RD_EPC   = 3'd4;
    localparam logic [2:0] S_REDIRECT = 3'd5;

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [MXLEN-1:0] pc_q;
    logic [MXLEN-1:0] cause_q;
    logic [MXLEN-1:0] target_q;
    logic             err_q;
    logic [MXLEN-1:0] tvec_base;
    logic [MXLEN-1:0] tvec_target;
    logic [MXLEN-1:0] epc_target;

    // Trap target from the mtvec value currently on the read port
    always_comb begin
        tvec_base   = {csr_rdata[MXLEN-1:2], 2'b00};
        tvec_target = tvec_base;
`ifdef VECTORED_TRAP_EN
        if (csr_rdata[1:0] == 2'b01 && cause_q[MXLEN-1]) begin
            tvec_target = tvec_base + MXLEN'({cause_q[MXLEN-2:0], 2'b00});
        end
`endif
        epc_target = {csr_rdata[MXLEN-1:2], 2'b00};
    end

    // Next-state, arbitration and CSR port drive; everything held at 0 during reset
    always_comb begin
        state_d        = state_q;
        trap_ack       = 1'b0;
        mret_ack       = 1'b0;
        core_csr_gnt   = 1'b0;
        csr_en         = 1'b0;
        csr_op         = 1'b0;
        csr_addr       = 12'h000;
        csr_wdata      = '0;
        redirect_valid = 1'b0;
        seq_err        = 1'b0;
        busy           = 1'b0;
        if (!rst) begin
            busy = (state_q != S_IDLE);
            case (state_q)
                S_IDLE: begin
                    if (trap_req) begin
                        trap_ack = 1'b1;
                        state_d  = S_WR_EPC;
                    end else if (mret_req) begin
                        mret_ack = 1'b1;
                        state_d  = S_RD_EPC;
                    end else if (core_csr_req) begin
                        core_csr_gnt = 1'b1;
                        csr_en       = 1'b1;
                        csr_op       = core_csr_op;
                        csr_addr     = core_csr_addr;
                        csr_wdata    = core_csr_wdata;
                    end
                end
                S_WR_EPC: begin
                    csr_en    = 1'b1;
                    csr_op    = 1'b1;
                    csr_addr  = MEPC_ADDR;
                    csr_wdata = pc_q;
                    state_d   = S_WR_CAUSE;
                end
                S_WR_CAUSE: begin
                    csr_en    = 1'b1;
                    csr_op    = 1'b1;
                    csr_addr  = MCAUSE_ADDR;
                    csr_wdata = cause_q;
                    state_d   = S_RD_TVEC;
                end
                S_RD_TVEC: begin
                    csr_en   = 1'b1;
                    csr_addr = MTVEC_ADDR;
                    state_d  = S_REDIRECT;
                end
                S_RD_EPC: begin
                    csr_en   = 1'b1;
                    csr_addr = MEPC_ADDR;
                    state_d  = S_REDIRECT;
                end
                S_REDIRECT: begin
                    redirect_valid = 1'b1;
                    seq_err        = err_q;
                    state_d        = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Core read path passes straight through from the CSR port while granted
    assign core_csr_rdata = core_csr_gnt ? csr_rdata : '0;
    assign core_csr_err   = core_csr_gnt & csr_err;
    assign redirect_pc    = target_q;

    // State, latched trap context, redirect target and sticky sequence error
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            cause_q  <= '0;
            target_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (trap_ack) begin
                pc_q    <= trap_pc;
                cause_q <= trap_cause;
            end
            if (state_q == S_RD_TVEC) begin
                target_q <= tvec_target;
            end else if (state_q == S_RD_EPC) begin
                target_q <= epc_target;
            end
            if (state_q == S_REDIRECT) begin
                err_q <= 1'b0;
            end else if (csr_en && !core_csr_gnt && csr_err) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Directed bench for csr_trap_sequencer with a behavioural CSR file and a redirect/read scoreboard.
module tb_csr_trap_sequencer;

    localparam logic [11:0] MTVEC  = 12'h305;
    localparam logic [11:0] MEPC   = 12'h341;
    localparam logic [11:0] MCAUSE = 12'h342;
`ifdef VECTORED_TRAP_EN
    localparam logic [31:0] VEC_IRQ_TARGET = 32'h8000_001C;
`else
    localparam logic [31:0] VEC_IRQ_TARGET = 32'h8000_0000;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        trap_req;
    logic [31:0] trap_pc;
    logic [31:0] trap_cause;
    logic        trap_ack;
    logic        mret_req;
    logic        mret_ack;
    logic        core_csr_req;
    logic        core_csr_op;
    logic [11:0] core_csr_addr;
    logic [31:0] core_csr_wdata;
    logic        core_csr_gnt;
    logic [31:0] core_csr_rdata;
    logic        core_csr_err;
    logic        csr_en;
    logic        csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        seq_err;
    logic        busy;

    logic [31:0] csr_mem [0:4095];
    logic        bk_we;
    logic [11:0] bk_addr;
    logic [31:0] bk_data;
    logic        err_force;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    csr_trap_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .trap_req       (trap_req),
        .trap_pc        (trap_pc),
        .trap_cause     (trap_cause),
        .trap_ack       (trap_ack),
        .mret_req       (mret_req),
        .mret_ack       (mret_ack),
        .core_csr_req   (core_csr_req),
        .core_csr_op    (core_csr_op),
        .core_csr_addr  (core_csr_addr),
        .core_csr_wdata (core_csr_wdata),
        .core_csr_gnt   (core_csr_gnt),
        .core_csr_rdata (core_csr_rdata),
        .core_csr_err   (core_csr_err),
        .csr_en         (csr_en),
        .csr_op         (csr_op),
        .csr_addr       (csr_addr),
        .csr_wdata      (csr_wdata),
        .csr_rdata      (csr_rdata),
        .csr_err        (csr_err),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .seq_err        (seq_err),
        .busy           (busy)
    );

    // Behavioural CSR file: combinational read, write on clock when no error
    assign csr_rdata = csr_mem[csr_addr];
    assign csr_err   = err_force;
    always @(posedge clk) begin
        if (bk_we) csr_mem[bk_addr] <= bk_data;
        else if (csr_en && csr_op && !csr_err) csr_mem[csr_addr] <= csr_wdata;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic poke(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        bk_we = 1'b1; bk_addr = a; bk_data = d;
        @(posedge clk);
        #1 bk_we = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            check(tag, obs, e);
        end
    endtask

    // Trap from IDLE; err_cycle selects which sequence cycle (1..3) sees csr_err, 0 = none
    task automatic do_trap(input string tag, input logic [31:0] pc, input logic [31:0] cause,
                           input logic [31:0] target, input int err_cycle, input logic exp_err);
        bit seen = 0;
        @(negedge clk);
        trap_req = 1'b1; trap_pc = pc; trap_cause = cause;
        #1 check({tag, "_ack"}, trap_ack, 1);
        exp_q.push_back(target);
        for (int i = 1; i <= 8 && !seen; i++) begin
            @(negedge clk);
            if (i == 1) trap_req = 1'b0;
            err_force = (i == err_cycle);
            #1;
            if (redirect_valid) begin
                seen = 1;
                check({tag, "_latency"}, 64'(i), 4);
                pop_check({tag, "_pc"}, redirect_pc);
                check({tag, "_seq_err"}, seq_err, 64'(exp_err));
            end
        end
        err_force = 1'b0;
        if (!seen) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic do_mret(input string tag, input logic [31:0] target);
        bit seen = 0;
        @(negedge clk);
        mret_req = 1'b1;
        #1 check({tag, "_ack"}, mret_ack, 1);
        exp_q.push_back(target);
        for (int i = 1; i <= 6 && !seen; i++) begin
            @(negedge clk);
            if (i == 1) mret_req = 1'b0;
            #1;
            if (redirect_valid) begin
                seen = 1;
                check({tag, "_latency"}, 64'(i), 2);
                pop_check({tag, "_pc"}, redirect_pc);
            end
        end
        if (!seen) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic core_acc(input string tag, input logic op, input logic [11:0] a,
                            input logic [31:0] wd, input logic err, input logic [31:0] exp_rd);
        @(negedge clk);
        core_csr_req = 1'b1; core_csr_op = op; core_csr_addr = a; core_csr_wdata = wd;
        err_force = err;
        #1 check({tag, "_gnt"}, core_csr_gnt, 1);
        check({tag, "_err"}, core_csr_err, 64'(err));
        if (!op) begin
            exp_q.push_back(exp_rd);
            pop_check({tag, "_rdata"}, core_csr_rdata);
        end
        @(negedge clk);
        core_csr_req = 1'b0; err_force = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; bk_we = 1'b0; bk_addr = '0; bk_data = '0; err_force = 1'b0;
        trap_req = 1'b1; trap_pc = 32'h0000_1234; trap_cause = 32'h2;
        mret_req = 1'b1;
        core_csr_req = 1'b1; core_csr_op = 1'b0; core_csr_addr = MCAUSE; core_csr_wdata = '0;
        poke(MTVEC, 32'h8000_0100);
        poke(MEPC, 32'h0);
        poke(MCAUSE, 32'h0);

        // Reset with every request active
        step();
        check("rst_trap_ack", trap_ack, 0);
        check("rst_mret_ack", mret_ack, 0);
        check("rst_gnt", core_csr_gnt, 0);
        check("rst_csr_en", csr_en, 0);
        check("rst_redirect", {redirect_valid, redirect_pc}, 0);
        check("rst_busy_seqerr", {busy, seq_err}, 0);

        // Release: trap beats mret and core
        @(negedge clk);
        rst = 1'b0;
        #1 check("arb_trap_ack", trap_ack, 1);
        check("arb_no_mret_ack", mret_ack, 0);
        check("arb_no_gnt", core_csr_gnt, 0);
        exp_q.push_back(32'h8000_0100);
        @(negedge clk);
        trap_req = 1'b0;
        #1 check("wr_epc_port", {busy, csr_en, csr_op, csr_addr, csr_wdata}, {3'b111, MEPC, 32'h1234});
        check("busy_no_mret", {mret_ack, core_csr_gnt}, 0);
        step();
        check("wr_cause_port", {csr_en, csr_op, csr_addr, csr_wdata}, {2'b11, MCAUSE, 32'h2});
        check("mepc_written", csr_mem[MEPC], 32'h1234);
        step();
        check("rd_tvec_port", {csr_en, csr_op, csr_addr}, {2'b10, MTVEC});
        check("mcause_written", csr_mem[MCAUSE], 32'h2);
        step();
        check("trap_redirect_valid", redirect_valid, 1);
        pop_check("trap_redirect_pc", redirect_pc);
        check("trap_redirect_idle_port", {csr_en, seq_err, busy}, 3'b001);
        // mret acked in the IDLE cycle after REDIRECT; core still waits
        step();
        check("arb_mret_ack", mret_ack, 1);
        check("arb_mret_no_gnt", core_csr_gnt, 0);
        exp_q.push_back(32'h1234);
        @(negedge clk);
        mret_req = 1'b0;
        #1 check("rd_epc_port", {csr_en, csr_op, csr_addr}, {2'b10, MEPC});
        step();
        check("arb_mret_redirect", redirect_valid, 1);
        pop_check("arb_mret_pc", redirect_pc);
        check("arb_redirect_no_gnt", core_csr_gnt, 0);
        step();
        check("arb_core_gnt", core_csr_gnt, 1);
        exp_q.push_back(32'h2);
        pop_check("arb_core_rdata", core_csr_rdata);
        core_csr_req = 1'b0;

        // mret strips the low two bits of mepc
        poke(MEPC, 32'h0000_2002);
        do_mret("mret", 32'h0000_2000);

        // Core accesses while idle
        core_acc("core_wr", 1'b1, MCAUSE, 32'h3232_4141, 1'b0, 32'h0);
        core_acc("core_rd", 1'b0, MCAUSE, 32'h0, 1'b0, 32'h3232_4141);
        core_acc("core_wr_err", 1'b1, MTVEC, 32'hDEAD_0000, 1'b1, 32'h0);

        // Sticky sequence error and its clearing
        poke(MTVEC, 32'h8000_0103);
        do_trap("trap_err", 32'h0000_0100, 32'hB, 32'h8000_0100, 2, 1'b1);
        do_trap("trap_clean", 32'h0000_0200, 32'hB, 32'h8000_0100, 0, 1'b0);
        do_mret("mret_after_trap", 32'h0000_0200);

        // Vectored mode: interrupt cause vs synchronous exception
        poke(MTVEC, 32'h8000_0001);
        do_trap("vec_irq", 32'h0000_0040, 32'h8000_0007, VEC_IRQ_TARGET, 0, 1'b0);
        do_trap("vec_exc", 32'h0000_0044, 32'h0000_0007, 32'h8000_0000, 0, 1'b0);

        // Reset in the middle of a trap sequence
        @(negedge clk);
        trap_req = 1'b1; trap_pc = 32'h0000_5550; trap_cause = 32'h5;
        #1 check("midrst_ack", trap_ack, 1);
        @(negedge clk);
        trap_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1 check("midrst_outputs", {busy, csr_en, redirect_valid}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("midrst_idle", {busy, redirect_valid, redirect_pc}, 0);
        check("midrst_mepc_kept", csr_mem[MEPC], 32'h0000_5550);
        for (int i = 0; i < 3; i++) begin
            step();
            check("midrst_no_redirect", {redirect_valid, busy}, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
